// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared mode codes, controller states and default sizing for the Mastermind game sequencer.
package mastermind_pkg;

    localparam int N_DIGITS_DEF  = 4;
    localparam int DIGIT_W_DEF   = 3;
    localparam int MAX_TRIES_DEF = 10;

    localparam logic [1:0] MODE_PW_IDLE  = 2'b00;
    localparam logic [1:0] MODE_PW_SET   = 2'b01;
    localparam logic [1:0] MODE_TRY_IDLE = 2'b10;
    localparam logic [1:0] MODE_TRY_SET  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PW,
        LOAD_GS,
        CMP_EXACT,
        CMP_NEAR,
        RESULT,
        OVER
    } ctrl_state_e;

endpackage

// File: rtl/mastermind_ctrl_if.sv
// mastermind_ctrl_if: mode/digit input side and score/status output side of the game sequencer.
interface mastermind_ctrl_if
    import mastermind_pkg::*;
#(
    parameter int N_DIGITS  = N_DIGITS_DEF,
    parameter int DIGIT_W   = DIGIT_W_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [1:0]         mode;
    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               pw_valid;
    logic               busy;
    logic               result_valid;
    logic [CW-1:0]      hits;
    logic [CW-1:0]      near;
    logic [TW-1:0]      tries;
    logic               win;
    logic               lose;
    logic               err;

    modport master (
        output mode, digit, enter,
        input  pw_valid, busy, result_valid, hits, near, tries, win, lose, err
    );

    modport slave (
        input  mode, digit, enter,
        output pw_valid, busy, result_valid, hits, near, tries, win, lose, err
    );

endinterface

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: sequential scorer, one exact position per cycle then one (guess,password) pair per cycle.
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int N_DIGITS = N_DIGITS_DEF,
    parameter int DIGIT_W  = DIGIT_W_DEF,
    localparam int CW      = $clog2(N_DIGITS + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [N_DIGITS-1:0][DIGIT_W-1:0] pw_i,
    input  logic [N_DIGITS-1:0][DIGIT_W-1:0] gs_i,
    output logic                             done_o,
    output logic [CW-1:0]                    hits_o,
    output logic [CW-1:0]                    near_o
);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

    ctrl_state_e         phase_q, phase_d;
    logic [IW-1:0]       i_q, i_d, j_q, j_d;
    logic [N_DIGITS-1:0] gused_q, gused_d, pused_q, pused_d;
    logic [CW-1:0]       hits_q, hits_d, near_q, near_d;
    logic                i_last, j_last;

    assign i_last = i_q == IW'(N_DIGITS - 1);
    assign j_last = j_q == IW'(N_DIGITS - 1);
    assign done_o = phase_q == CMP_NEAR && i_last && j_last;
    assign hits_o = hits_q;
    assign near_o = near_q;

    // Exact pass marks matched slots used so the near pass credits each digit at most once.
    always_comb begin
        phase_d = phase_q;
        i_d     = i_q;
        j_d     = j_q;
        gused_d = gused_q;
        pused_d = pused_q;
        hits_d  = hits_q;
        near_d  = near_q;
        if (start_i) begin
            phase_d = CMP_EXACT;
            i_d     = '0;
            j_d     = '0;
            gused_d = '0;
            pused_d = '0;
            hits_d  = '0;
            near_d  = '0;
        end else if (phase_q == CMP_EXACT) begin
            if (gs_i[i_q] == pw_i[i_q]) begin
                hits_d       = hits_q + 1'b1;
                gused_d[i_q] = 1'b1;
                pused_d[i_q] = 1'b1;
            end
            i_d     = i_last ? '0 : i_q + 1'b1;
            phase_d = i_last ? CMP_NEAR : CMP_EXACT;
        end else if (phase_q == CMP_NEAR) begin
            if (!gused_q[i_q] && !pused_q[j_q] && gs_i[i_q] == pw_i[j_q]) begin
                near_d       = near_q + 1'b1;
                gused_d[i_q] = 1'b1;
                pused_d[j_q] = 1'b1;
            end
            j_d     = j_last ? '0 : j_q + 1'b1;
            i_d     = j_last ? (i_last ? '0 : i_q + 1'b1) : i_q;
            phase_d = (i_last && j_last) ? IDLE : CMP_NEAR;
        end
    end

    // Scoring state register; hits/near hold until the next start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            gused_q <= '0;
            pused_q <= '0;
            hits_q  <= '0;
            near_q  <= '0;
        end else begin
            phase_q <= phase_d;
            i_q     <= i_d;
            j_q     <= j_d;
            gused_q <= gused_d;
            pused_q <= pused_d;
            hits_q  <= hits_d;
            near_q  <= near_d;
        end
    end

endmodule

// File: rtl/mastermind_ctrl.sv
// mastermind_ctrl: Mastermind game sequencer (password/guess entry, scoring hand-off, tries, win/lose).
// Define MASTERMIND_DUP_REJECT_EN to reject password digits already stored (err pulses instead).
module mastermind_ctrl
    import mastermind_pkg::*;
#(
    parameter int N_DIGITS  = N_DIGITS_DEF,
    parameter int DIGIT_W   = DIGIT_W_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input logic               clk_i,
    input logic               rst_ni,
    mastermind_ctrl_if.slave  bus
);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    ctrl_state_e                      state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [N_DIGITS-1:0][DIGIT_W-1:0] pw_q, pw_d, gs_q, gs_d;
    logic                             pw_valid_q, pw_valid_d;
    logic                             win_q, win_d, lose_q, lose_d;
    logic [TW-1:0]                    tries_q, tries_d;
    logic                             start, done, dup, last;
    logic [CW-1:0]                    hits, near;

    assign last = idx_q == IW'(N_DIGITS - 1);

`ifdef MASTERMIND_DUP_REJECT_EN
    logic err_q, err_d;

    // A digit already present in the filled part of the password is a duplicate.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < N_DIGITS; k++)
            if (IW'(k) < idx_q && pw_q[k] == bus.digit) dup = 1'b1;
    end

    assign err_d = state_q == LOAD_PW && bus.mode == MODE_PW_SET && bus.enter && !pw_valid_q && dup;

    // Rejection flag registered into a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign dup     = 1'b0;
    assign bus.err = 1'b0;
`endif

    mastermind_scorer #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W)
    ) u_scorer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start),
        .pw_i    (pw_q),
        .gs_i    (gs_q),
        .done_o  (done),
        .hits_o  (hits),
        .near_o  (near)
    );

    // Entry FSM; CMP_EXACT here covers the whole scorer run (exact then near passes).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pw_d       = pw_q;
        gs_d       = gs_q;
        pw_valid_d = pw_valid_q;
        tries_d    = tries_q;
        win_d      = win_q;
        lose_d     = lose_q;
        start      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mode == MODE_PW_SET) begin
                    state_d    = LOAD_PW;
                    idx_d      = '0;
                    pw_valid_d = 1'b0;
                    tries_d    = '0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                end else if (bus.mode == MODE_TRY_SET && pw_valid_q && !win_q && !lose_q) begin
                    state_d = LOAD_GS;
                    idx_d   = '0;
                end
            end
            LOAD_PW: begin
                if (bus.mode != MODE_PW_SET) begin
                    state_d = IDLE;
                end else if (bus.enter && !pw_valid_q && !dup) begin
                    pw_d[idx_q] = bus.digit;
                    idx_d       = idx_q + 1'b1;
                    pw_valid_d  = last;
                end
            end
            LOAD_GS: begin
                if (bus.mode != MODE_TRY_SET) begin
                    state_d = IDLE;
                end else if (bus.enter) begin
                    gs_d[idx_q] = bus.digit;
                    idx_d       = idx_q + 1'b1;
                    state_d     = last ? CMP_EXACT : LOAD_GS;
                    start       = last;
                end
            end
            CMP_EXACT: state_d = done ? RESULT : CMP_EXACT;
            RESULT: begin
                tries_d = tries_q + 1'b1;
                if (hits == CW'(N_DIGITS)) begin
                    win_d   = 1'b1;
                    state_d = OVER;
                end else if (tries_d == TW'(MAX_TRIES)) begin
                    lose_d  = 1'b1;
                    state_d = OVER;
                end else begin
                    state_d = IDLE;
                end
            end
            OVER: begin
                if (bus.mode == MODE_PW_IDLE) begin
                    state_d    = IDLE;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    pw_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, stored digits and game flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pw_q       <= '0;
            gs_q       <= '0;
            pw_valid_q <= 1'b0;
            tries_q    <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pw_q       <= pw_d;
            gs_q       <= gs_d;
            pw_valid_q <= pw_valid_d;
            tries_q    <= tries_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign bus.pw_valid     = pw_valid_q;
    assign bus.busy         = state_q == CMP_EXACT;
    assign bus.result_valid = state_q == RESULT;
    assign bus.hits         = hits;
    assign bus.near         = near;
    assign bus.tries        = tries_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;

endmodule

// File: tb/tb_mastermind_ctrl.sv
// tb_mastermind_ctrl: table vectors, randomized games against a counting reference model, and corner sequences.
module tb_mastermind_ctrl;
    import mastermind_pkg::*;

    typedef logic [3:0][2:0] dig4_t;

    typedef struct packed {
        dig4_t      pw;
        dig4_t      gs;
        logic [2:0] hits;
        logic [2:0] near;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_seen = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mastermind_ctrl_if #(.N_DIGITS(4), .DIGIT_W(3), .MAX_TRIES(10)) bus ();

    mastermind_ctrl #(.N_DIGITS(4), .DIGIT_W(3), .MAX_TRIES(10)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always @(negedge clk) if (bus.err) err_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    function automatic dig4_t mk(input int a, input int b, input int c, input int d);
        dig4_t r;
        r[0] = 3'(a);
        r[1] = 3'(b);
        r[2] = 3'(c);
        r[3] = 3'(d);
        return r;
    endfunction

    // Reference scoring: hits by position, near = sum of per-symbol min counts minus hits.
    function automatic void score(input dig4_t p, input dig4_t g, output int h, output int n);
        int cp[8];
        int cg[8];
        h = 0;
        n = 0;
        for (int s = 0; s < 8; s++) begin
            cp[s] = 0;
            cg[s] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (p[k] == g[k]) h++;
            cp[p[k]]++;
            cg[g[k]]++;
        end
        for (int s = 0; s < 8; s++) n += (cp[s] < cg[s]) ? cp[s] : cg[s];
        n -= h;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        bus.mode = m;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_digit(input logic [2:0] d);
        @(negedge clk);
        bus.digit = d;
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
    endtask

    task automatic load_pw(input dig4_t p);
        set_mode(MODE_PW_IDLE);
        set_mode(MODE_PW_SET);
        for (int k = 0; k < 4; k++) enter_digit(p[k]);
        check("pw_valid_after_load", int'(bus.pw_valid), 1);
        set_mode(MODE_TRY_SET);
    endtask

    // lat = cycle (after the last enter) on which result_valid was seen, 0 if never within budget.
    task automatic run_guess(input dig4_t g, output int lat, output logic busy1);
        lat = 0;
        busy1 = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) enter_digit(g[k]);
        @(negedge clk);
        bus.digit = g[3];
        bus.enter = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.enter = 1'b0;
            if (k == 1) busy1 = bus.busy;
            if (bus.result_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int    lat, h, n, tries_m, ng, base;
        logic  b1, win_m, lose_m;
        dig4_t p, g;

        bus.mode  = MODE_PW_IDLE;
        bus.digit = '0;
        bus.enter = 1'b0;

        tbl.push_back('{mk(1,2,3,4), mk(1,2,3,4), 3'd4, 3'd0});
        tbl.push_back('{mk(1,2,3,4), mk(4,3,2,1), 3'd0, 3'd4});
`ifndef MASTERMIND_DUP_REJECT_EN
        tbl.push_back('{mk(1,1,2,2), mk(1,2,1,0), 3'd1, 3'd2});
`endif
        tbl.push_back('{mk(5,6,7,0), mk(6,5,0,7), 3'd0, 3'd4});
        tbl.push_back('{mk(0,1,2,3), mk(0,7,7,7), 3'd1, 3'd0});
        tbl.push_back('{mk(3,1,4,2), mk(1,3,3,3), 3'd0, 3'd2});
        tbl.push_back('{mk(7,6,5,4), mk(7,6,4,5), 3'd2, 3'd2});

        repeat (2) @(negedge clk);
        check("reset_pw_valid", int'(bus.pw_valid), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_result_valid", int'(bus.result_valid), 0);
        check("reset_hits", int'(bus.hits), 0);
        check("reset_near", int'(bus.near), 0);
        check("reset_tries", int'(bus.tries), 0);
        check("reset_win", int'(bus.win), 0);
        check("reset_lose", int'(bus.lose), 0);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            load_pw(tbl[r].pw);
            run_guess(tbl[r].gs, lat, b1);
            check("tbl_latency", lat, 21);
            check("tbl_busy", int'(b1), 1);
            check("tbl_hits", int'(bus.hits), int'(tbl[r].hits));
            check("tbl_near", int'(bus.near), int'(tbl[r].near));
            @(negedge clk);
            check("tbl_win", int'(bus.win), int'(tbl[r].hits == 3'd4));
            check("tbl_tries", int'(bus.tries), 1);
        end

        for (int gm = 0; gm < 15; gm++) begin
            base = int'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) begin
`ifdef MASTERMIND_DUP_REJECT_EN
                p[k] = 3'((base + k) % 8);
`else
                p[k] = 3'($urandom_range(0, 7));
`endif
            end
            load_pw(p);
            tries_m = 0;
            win_m   = 1'b0;
            lose_m  = 1'b0;
            ng      = int'($urandom_range(1, 4));
            for (int q = 0; q < ng && !win_m && !lose_m; q++) begin
                case ($urandom_range(0, 3))
                    0: g = p;
                    1: for (int k = 0; k < 4; k++) g[k] = p[(k + 1) % 4];
                    default: for (int k = 0; k < 4; k++) g[k] = 3'($urandom_range(0, 7));
                endcase
                score(p, g, h, n);
                run_guess(g, lat, b1);
                check("rnd_latency", lat, 21);
                check("rnd_hits", int'(bus.hits), h);
                check("rnd_near", int'(bus.near), n);
                tries_m++;
                if (h == 4) win_m = 1'b1;
                else if (tries_m == 10) lose_m = 1'b1;
                @(negedge clk);
                check("rnd_tries", int'(bus.tries), tries_m);
                check("rnd_win", int'(bus.win), int'(win_m));
                check("rnd_lose", int'(bus.lose), int'(lose_m));
            end
        end

        // Ten misses lose the game; an eleventh guess is ignored; mode 00 clears.
        load_pw(mk(0,1,2,3));
        for (int t = 1; t <= 10; t++) begin
            run_guess(mk(7,7,7,7), lat, b1);
            check("lose_latency", lat, 21);
            check("lose_hits_near", int'(bus.hits) + int'(bus.near), 0);
            @(negedge clk);
            check("lose_flag", int'(bus.lose), int'(t == 10));
        end
        check("lose_tries", int'(bus.tries), 10);
        run_guess(mk(0,1,2,3), lat, b1);
        check("over_guess_ignored", lat, 0);
        check("over_tries_held", int'(bus.tries), 10);
        check("over_win_clear", int'(bus.win), 0);
        set_mode(MODE_PW_IDLE);
        check("over_lose_cleared", int'(bus.lose), 0);
        check("over_pw_valid_cleared", int'(bus.pw_valid), 0);

        // Leaving password mode after two digits leaves no usable password.
        set_mode(MODE_PW_SET);
        enter_digit(3'd1);
        enter_digit(3'd2);
        set_mode(MODE_TRY_SET);
        check("partial_pw_valid", int'(bus.pw_valid), 0);
        run_guess(mk(1,2,3,4), lat, b1);
        check("partial_guess_ignored", lat, 0);
        check("partial_busy", int'(b1), 0);

        // Asynchronous reset in the middle of the near pass.
        load_pw(mk(1,2,3,4));
        run_guess(mk(0,0,0,0), lat, b1);
        @(negedge clk);
        check("pre_reset_tries", int'(bus.tries), 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) enter_digit(3'd5);
        @(negedge clk);
        bus.digit = 3'd5;
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        repeat (9) @(negedge clk);
        check("near_phase_busy", int'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_result_valid", int'(bus.result_valid), 0);
        check("rst_tries", int'(bus.tries), 0);
        check("rst_pw_valid", int'(bus.pw_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MASTERMIND_DUP_REJECT_EN
        err_seen = 0;
        set_mode(MODE_PW_IDLE);
        set_mode(MODE_PW_SET);
        enter_digit(3'd5);
        enter_digit(3'd5);
        enter_digit(3'd6);
        enter_digit(3'd7);
        enter_digit(3'd0);
        @(negedge clk);
        check("dup_err_pulses", err_seen, 1);
        check("dup_pw_valid", int'(bus.pw_valid), 1);
        set_mode(MODE_TRY_SET);
        run_guess(mk(5,6,7,0), lat, b1);
        check("dup_latency", lat, 21);
        check("dup_stored_hits", int'(bus.hits), 4);
`else
        check("err_never_pulses", err_seen, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mastermind_ctrl.md
Name: mastermind_ctrl

Overview:
- Game sequencer that sits downstream of the mode FSM.
- Consumes the 2-bit mode code (00 password-idle, 01 password-set, 10 attempt-idle, 11 attempt-set) and one digit per `enter` pulse.
- Stores the secret password and captures guesses.
- Scores each guess sequentially into exact hits and near (right digit, wrong place) counts.
- Tracks attempts and declares win/lose.

Parameters:
- N_DIGITS, 4, digits per password/guess
- DIGIT_W, 3, bits per digit (8 symbols)
- MAX_TRIES, 10, attempts before loss

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- mode  in  2  mode code from mode FSM {s1,s0}
- digit  in  DIGIT_W  digit value, sampled when enter=1
- enter  in  1  single-cycle digit strobe
- pw_valid  out  1  full password stored
- busy  out  1  scoring in progress
- result_valid  out  1  one-cycle pulse; hits/near valid
- hits  out  $clog2(N_DIGITS+1)  exact-position matches of last guess
- near  out  $clog2(N_DIGITS+1)  misplaced matches of last guess
- tries  out  $clog2(MAX_TRIES+1)  attempts scored since password set
- win  out  1  sticky game-won flag
- lose  out  1  sticky game-lost flag
- err  out  1  one-cycle pulse on rejected digit (optional feature)

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; all outputs 0; password, guess, index and flags cleared.
- States: IDLE, LOAD_PW, LOAD_GS, CMP_EXACT, CMP_NEAR, RESULT, OVER.

Transitions:
- IDLE -> LOAD_PW when mode=01.
  - On entry: digit index=0, pw_valid=0, tries=0, win=lose=0.
- LOAD_PW: each `enter` stores `digit` at pw[idx] and increments idx.
  - When idx reaches N_DIGITS: pw_valid=1 the next cycle; further enters ignored.
  - If mode leaves 01 before N_DIGITS digits are stored: pw_valid stays 0, return to IDLE.
- Mode 10/11 with pw_valid=0: all enters ignored; remain IDLE.
- IDLE -> LOAD_GS when mode=11, pw_valid=1, win=lose=0.
  - On entry: idx=0.
  - Each `enter` stores gs[idx].
  - The N-th enter moves to CMP_EXACT on the next cycle; busy=1.
  - Mode leaving 11 mid-guess: partial guess discarded, no try counted, back to IDLE.
- CMP_EXACT: one position per cycle, i = 0..N_DIGITS-1.
  - When gs[i]==pw[i]: hits++ and set gused[i]=pused[i]=1.
  - Exactly N_DIGITS cycles.
- CMP_NEAR: one (i,j) pair per cycle, i outer, j inner; exactly N_DIGITS*N_DIGITS cycles.
  - Condition: !gused[i] && !pused[j] && gs[i]==pw[j].
  - On match: near++, gused[i]=1, pused[j]=1.
  - Each password digit is credited at most once, and each guess digit at most once.
- RESULT (1 cycle):
  - result_valid=1, busy=0, tries++.
  - If hits==N_DIGITS: win=1, go to OVER.
  - Else if tries (post-increment)==MAX_TRIES: lose=1, go to OVER.
  - Else go to IDLE.
- Latency: the last guess enter is at cycle 0; result_valid is at cycle N_DIGITS + N_DIGITS² + 1 (21 for N_DIGITS=4).
- hits/near hold their values until the next CMP_EXACT entry, which clears them.
- OVER: win/lose held; enters ignored. mode=00 returns to IDLE, clearing win, lose and pw_valid.
- During CMP_* states: enter and mode changes are ignored; scoring always completes, then mode is re-evaluated.
- Mode change from 00 directly to 01 while pw_valid=1: the password is overwritten (new game).

Optional Feature:
- MASTERMIND_DUP_REJECT_EN defined:
  - In LOAD_PW, a digit equal to any already-stored password digit is not stored.
  - idx does not advance; err pulses for 1 cycle.
- Undefined: duplicates accepted; err tied 0.

Decomposition:
- Package mastermind_pkg:
  - Mode code constants (MODE_PW_IDLE=2'b00, MODE_PW_SET=2'b01, MODE_TRY_IDLE=2'b10, MODE_TRY_SET=2'b11).
  - Controller state enum.
  - Default N_DIGITS/DIGIT_W/MAX_TRIES.
- Sub-module mastermind_scorer holds CMP_EXACT/CMP_NEAR:
  - Inputs: start, pw, gs.
  - Outputs: done, hits, near.
  - The top keeps the entry FSM, tries and win/lose.

Test Plan:
- Password 1,2,3,4 then guess 1,2,3,4 -> result_valid at cycle 21; hits=4, near=0, win=1, tries=1.
- Password 1,2,3,4, guess 4,3,2,1 -> hits=0, near=4, win=0.
- Password 1,1,2,2, guess 1,2,1,0 (dup macro off) -> hits=1, near=2.
- Ten wrong guesses 7,7,7,7 vs 0,1,2,3 -> lose=1 after the 10th result_valid; 11th guess ignored; mode=00 clears lose.
- Mode 01 -> 11 after 2 password digits -> pw_valid=0, guess enters ignored.
- Reset pulse in CMP_NEAR -> busy, result_valid, tries and pw_valid all 0 immediately.
- With MASTERMIND_DUP_REJECT_EN: password enters 5,5,6,7,0 -> err pulse on the second 5; stored password 5,6,7,0.
